// File: rtl/fifo_rd_pkg.sv
// Shared constants and small helpers for the FIFO-to-stream reader.
package fifo_rd_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned PKT_LEN_DEF    = 16;
   localparam int unsigned BUF_DEPTH      = 3;
   localparam int unsigned PKT_CNT_W      = 16;

   // Wide enough for occupancy 0..BUF_DEPTH and pointers 0..BUF_DEPTH-1
   typedef logic [1:0] buf_idx_t;

   function automatic buf_idx_t buf_ptr_inc(input buf_idx_t ptr);
      return (ptr == buf_idx_t'(BUF_DEPTH - 1)) ? '0 : ptr + buf_idx_t'(1);
   endfunction

   function automatic int unsigned beat_cnt_w(input int unsigned pkt_len);
      return $clog2(pkt_len + 1);
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read side and stream output side of the reader, bundled for port connection.
interface fifo_stream_reader_if #(
   parameter int unsigned DATA_WIDTH = fifo_rd_pkg::DATA_WIDTH_DEF
);
   logic                             fifo_empty;
   logic                             fifo_rd_en;
   logic [DATA_WIDTH-1:0]            fifo_dout;
   logic                             m_valid;
   logic                             m_ready;
   logic [DATA_WIDTH-1:0]            m_data;
   logic                             m_last;
   logic [fifo_rd_pkg::PKT_CNT_W-1:0] pkt_count;

   modport master (
      input  fifo_empty, fifo_dout, m_ready,
      output fifo_rd_en, m_valid, m_data, m_last, pkt_count
   );

   modport slave (
      output fifo_empty, fifo_dout, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_last, pkt_count
   );
endinterface

// File: rtl/fifo_stream_reader_buf.sv
// stream_buf: 3-entry circular output buffer with push/pop, head and occupancy.
module stream_buf import fifo_rd_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output buf_idx_t              occupancy
);
   typedef logic [DATA_WIDTH-1:0] word_t;

   word_t    mem_q [BUF_DEPTH];
   word_t    mem_d [BUF_DEPTH];
   buf_idx_t rd_ptr_q, rd_ptr_d;
   buf_idx_t wr_ptr_q, wr_ptr_d;
   buf_idx_t occ_q, occ_d;
   logic     push_ok, pop_ok;

   always_comb begin
      pop_ok   = pop && (occ_q != '0);
      // A full buffer may still accept a word when the head leaves the same cycle
      push_ok  = push && ((occ_q != buf_idx_t'(BUF_DEPTH)) || pop_ok);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = buf_ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = buf_ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   occ_d = occ_q + buf_idx_t'(1);
         2'b01:   occ_d = occ_q - buf_idx_t'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign occupancy = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads words from a first-word-latency-1 FIFO and emits them as a packetised
// valid/ready stream, with beat and packet counters.
module fifo_stream_reader import fifo_rd_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned PKT_LEN    = PKT_LEN_DEF
) (
   input logic                  clk,
   input logic                  rst,
   fifo_stream_reader_if.master bus
);
   localparam int unsigned BEAT_W = beat_cnt_w(PKT_LEN);

   typedef logic [BEAT_W-1:0]    beat_t;
   typedef logic [PKT_CNT_W-1:0] pkt_t;

   localparam beat_t LAST_BEAT = beat_t'(PKT_LEN - 1);

   logic                  rst_hold_q, rst_hold_d;
   logic                  inflight_q, inflight_d;
   beat_t                 beat_q, beat_d;
   pkt_t                  pkt_q, pkt_d;
   logic                  rd_en, valid, fire, last;
   buf_idx_t              occ;
   logic [DATA_WIDTH-1:0] head;

   stream_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (bus.fifo_dout),
      .pop       (fire),
      .head      (head),
      .occupancy (occ)
   );

   // rst_hold_q keeps reads off until the cycle after reset deasserts while
   // leaving rd_en a function of registered state and fifo_empty only
   always_comb begin
      rd_en = !rst_hold_q && !bus.fifo_empty &&
              (({1'b0, occ} + {2'b00, inflight_q}) < 3'(BUF_DEPTH));
      valid = (occ != '0);
      fire  = valid && bus.m_ready;
      last  = valid && (beat_q == LAST_BEAT);
   end

   always_comb begin
      rst_hold_d = 1'b0;
      inflight_d = rd_en;
      beat_d     = beat_q;
      pkt_d      = pkt_q;
      if (fire) begin
         if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            pkt_d  = pkt_q + pkt_t'(1);
         end else begin
            beat_d = beat_q + beat_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_hold_q <= 1'b1;
         inflight_q <= 1'b0;
         beat_q     <= '0;
         pkt_q      <= '0;
      end else begin
         rst_hold_q <= rst_hold_d;
         inflight_q <= inflight_d;
         beat_q     <= beat_d;
         pkt_q      <= pkt_d;
      end
   end

   always_comb begin
      bus.fifo_rd_en = rd_en;
      bus.m_valid    = valid;
      bus.m_data     = head;
      bus.m_last     = last;
      bus.pkt_count  = pkt_q;
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: FIFO model plus an in-order word scoreboard with
// beat/packet arithmetic, directed scenarios and a randomized phase.
module tb_fifo_stream_reader;
   localparam int unsigned DW = 8;
   localparam int unsigned PL = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
   fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus1 ();

   fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
      .clk (clk), .rst (rst), .bus (bus)
   );
   fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut1 (
      .clk (clk), .rst (rst), .bus (bus1)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] fifo_q[$];   // words still inside the external FIFO
   logic [DW-1:0] exp_q[$];    // every word expected on the stream, in order
   int n_read, n_xfer, max_out, cyc, rd_empty_cnt;
   int first_rd_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc;
   int ready_mode;             // 0: ready=1, 1: toggle, 2: random, 3: ready=0
   logic          stall_prev;
   logic [DW-1:0] stall_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      bus.fifo_empty = 1'b0;
   endtask

   task automatic tick();
      logic          rd, fire, have;
      logic [DW-1:0] e;
      int            drop;
      @(negedge clk);
      rd   = bus.fifo_rd_en;
      fire = bus.m_valid && bus.m_ready;
      if (!rst) begin
         if (rd && fifo_q.size() == 0) rd_empty_cnt++;
         if (rd && first_rd_cyc < 0) first_rd_cyc = cyc;
         if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (stall_prev) begin
            check_eq("hold_valid", bus.m_valid, 1'b1);
            check_eq("hold_data", bus.m_data, stall_data);
         end
         if (bus.m_valid) check_eq("m_last", bus.m_last, (n_xfer % PL) == (PL - 1));
         else             check_eq("m_last_idle", bus.m_last, 1'b0);
         check_eq("pkt_count", bus.pkt_count, 32'((n_xfer / PL) % 65536));
         if (fire) begin
            have = (exp_q.size() != 0);
            check_eq("beat_expected", have, 1'b1);
            if (have) begin
               e = exp_q.pop_front();
               check_eq("m_data", bus.m_data, e);
            end
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
         end
         stall_prev = bus.m_valid && !bus.m_ready;
         stall_data = bus.m_data;
      end else begin
         stall_prev = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rd && fifo_q.size() != 0) bus.fifo_dout = fifo_q.pop_front();
      if (rst) begin
         // Words that left the FIFO but never transferred are lost on reset
         drop = n_read + (rd ? 1 : 0) - n_xfer;
         for (int i = 0; i < drop; i++) if (exp_q.size() != 0) exp_q.delete(0);
         n_read = 0;
         n_xfer = 0;
      end else begin
         if (rd) n_read++;
         if (fire) n_xfer++;
         if (n_read - n_xfer > max_out) max_out = n_read - n_xfer;
      end
      bus.fifo_empty = (fifo_q.size() == 0);
      case (ready_mode)
         0:       bus.m_ready = 1'b1;
         1:       bus.m_ready = ~bus.m_ready;
         2:       bus.m_ready = 1'($urandom % 2);
         default: bus.m_ready = 1'b0;
      endcase
   endtask

   task automatic run_until(input int target, input int budget, input string tag);
      int n = 0;
      while (n_xfer < target && n < budget) begin
         tick();
         n++;
      end
      check_eq({tag, "_beats"}, 32'(n_xfer), 32'(target));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rd_en"}, bus.fifo_rd_en, 1'b0);
      check_eq({tag, "_valid"}, bus.m_valid, 1'b0);
      check_eq({tag, "_last"}, bus.m_last, 1'b0);
      check_eq({tag, "_data"}, bus.m_data, '0);
      check_eq({tag, "_pkt"}, bus.pkt_count, '0);
   endtask

   initial begin
      int            deassert_cyc, guard, xf, cy;
      logic          rd1, f1;
      logic [DW-1:0] w1, nxt;

      rst = 1'b1;
      bus.fifo_empty  = 1'b1;
      bus.fifo_dout   = '0;
      bus.m_ready     = 1'b1;
      bus1.fifo_empty = 1'b1;
      bus1.fifo_dout  = '0;
      bus1.m_ready    = 1'b1;
      n_read = 0; n_xfer = 0; max_out = 0; cyc = 0; rd_empty_cnt = 0;
      first_rd_cyc = -1; first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
      ready_mode = 0;
      stall_prev = 1'b0;
      stall_data = '0;

      // Reset held with a loaded FIFO: no reads, outputs cleared
      for (int i = 0; i < 16; i++) push_word(8'(i));
      repeat (3) tick();
      check_reset_outputs("rst");

      // Straight packet at full rate
      rst = 1'b0;
      deassert_cyc = cyc;
      check_eq("rd_at_deassert", bus.fifo_rd_en, 1'b0);
      run_until(16, 40, "pkt0");
      check_eq("first_rd_after_deassert", first_rd_cyc > deassert_cyc, 1'b1);
      check_eq("rd_to_valid_latency", 32'(first_valid_cyc - first_rd_cyc), 32'd2);
      check_eq("back_to_back_span", 32'(last_xfer_cyc - first_xfer_cyc), 32'd15);
      check_eq("pkt_after_first", bus.pkt_count, 16'd1);

      // Toggling ready
      ready_mode = 1;
      max_out = 0;
      for (int i = 16; i < 32; i++) push_word(8'(i));
      run_until(32, 80, "toggle");
      check_eq("outstanding_toggle", max_out <= 3, 1'b1);
      check_eq("pkt_after_toggle", bus.pkt_count, 16'd2);

      // Downstream stalled: exactly three reads, then release
      ready_mode = 3;
      bus.m_ready = 1'b0;
      max_out = 0;
      for (int i = 0; i < 8; i++) push_word(8'($urandom));
      repeat (10) tick();
      check_eq("stalled_reads", 32'(n_read - n_xfer), 32'd3);
      check_eq("stalled_rd_en", bus.fifo_rd_en, 1'b0);
      ready_mode = 0;
      run_until(40, 30, "release");
      check_eq("release_no_loss", 32'(exp_q.size()), 32'd0);

      // FIFO runs dry mid-packet
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i));
      run_until(8, 30, "half_a");
      repeat (4) tick();
      check_eq("gap_valid", bus.m_valid, 1'b0);
      check_eq("gap_pkt", bus.pkt_count, 16'd0);
      for (int i = 8; i < 16; i++) push_word(8'(8'h40 + i));
      run_until(16, 30, "half_b");
      check_eq("pkt_after_gap", bus.pkt_count, 16'd1);

      // Reset with two buffered beats and a read in flight
      ready_mode = 3;
      bus.m_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) push_word(8'(8'hA0 + i));
      guard = 0;
      while (n_read < 3 && guard < 10) begin
         tick();
         guard++;
      end
      check_eq("pre_rst_reads", 32'(n_read), 32'd3);
      check_eq("pre_rst_valid", bus.m_valid, 1'b1);
      rst = 1'b1;
      tick();
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      ready_mode = 0;
      run_until(2, 20, "post_rst");
      check_eq("post_rst_empty", 32'(exp_q.size()), 32'd0);

      // Randomized traffic with one reset in the middle
      ready_mode = 2;
      max_out = 0;
      for (int i = 0; i < 400; i++) begin
         rst = (i == 200);
         if (($urandom % 3) == 0 && fifo_q.size() < 6) push_word(8'($urandom));
         tick();
      end
      rst = 1'b0;
      ready_mode = 0;
      run_until(n_xfer + exp_q.size(), 40, "rand_drain");
      check_eq("rand_drained_valid", bus.m_valid, 1'b0);
      check_eq("rand_outstanding", max_out <= 3, 1'b1);
      check_eq("rd_when_empty", 32'(rd_empty_cnt), 32'd0);

      // PKT_LEN=1 instance: every beat is last, packet counter wraps
      xf = 0; cy = 0; w1 = '0; nxt = '0;
      bus1.fifo_empty = 1'b0;
      while (xf < 65536 && cy < 70000) begin
         @(negedge clk);
         rd1 = bus1.fifo_rd_en;
         f1  = bus1.m_valid && bus1.m_ready;
         if (f1) begin
            check_eq("p1_last", bus1.m_last, 1'b1);
            check_eq("p1_data", bus1.m_data, nxt);
            nxt = nxt + 8'd1;
         end
         @(posedge clk);
         #1;
         cy++;
         if (rd1) begin
            bus1.fifo_dout = w1;
            w1 = w1 + 8'd1;
         end
         if (f1) xf++;
         if (f1 && xf == 65535) check_eq("p1_pkt_ffff", bus1.pkt_count, 16'hFFFF);
      end
      bus1.fifo_empty = 1'b1;
      check_eq("p1_beats", 32'(xf), 32'd65536);
      check_eq("p1_pkt_wrap", bus1.pkt_count, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO/stream data width in bits.
REQ-002 SHALL have parameter PKT_LEN, default 16, beats per packet (legal 1..256).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port fifo_rd_en  output  1  FIFO read strobe; each strobe requests one word.
REQ-007 SHALL have port fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted fifo_rd_en.
REQ-008 SHALL have port m_valid  output  1  stream beat valid.
REQ-009 SHALL have port m_ready  input  1  downstream accept.
REQ-010 SHALL have port m_data  output  DATA_WIDTH  stream beat data.
REQ-011 SHALL have port m_last  output  1  final beat of a packet.
REQ-012 SHALL have port pkt_count  output  16  completed packets, wraps 0xFFFF->0.

Function
REQ-013 A read SHALL be issued (fifo_rd_en=1) only when fifo_empty=0 and occupancy+inflight<3, where occupancy is the number of entries in a 3-entry output buffer and inflight is 1 if fifo_rd_en was high the previous cycle.
REQ-014 fifo_rd_en SHALL be a pure function of registered state and fifo_empty; it SHALL have no combinational path from m_ready.
REQ-015 The word on fifo_dout SHALL be written into the buffer tail exactly one cycle after each issued read, and never otherwise.
REQ-016 m_valid SHALL be 1 iff occupancy>0; m_data SHALL be the buffer head.
REQ-017 A beat SHALL transfer on the cycle m_valid=1 and m_ready=1, which pops the head.
REQ-018 Once m_valid is 1, m_valid and m_data SHALL hold stable until that beat transfers.
REQ-019 Simultaneous pop and landing SHALL leave occupancy unchanged; the buffer SHALL never overflow or underflow.
REQ-020 Minimum latency SHALL be 2 cycles: rd_en at cycle N, then m_valid=1 at N+2 with an empty buffer.
REQ-021 With the FIFO non-empty and m_ready held at 1, the block SHALL sustain one beat per cycle after the initial latency.
REQ-022 A beat counter of ceil(log2(PKT_LEN+1)) bits SHALL increment on each transfer.
REQ-023 m_last SHALL be 1 when m_valid=1 and the beat counter equals PKT_LEN-1; on transfer of that beat the counter SHALL return to 0 and pkt_count SHALL increment.
REQ-024 With PKT_LEN=1, every beat SHALL carry m_last=1.
REQ-025 The FIFO going empty mid-packet SHALL only pause the stream; the beat count SHALL persist with no partial-packet flush.

Reset
REQ-026 While rst=1, on the clock edge: occupancy=0, inflight=0, beat counter=0, pkt_count=0, fifo_rd_en=0, m_valid=0, m_last=0, m_data=0.
REQ-027 Reset asserted with a read in flight SHALL discard the word landing the next cycle.
REQ-028 Reset asserted with buffered beats SHALL drop those beats.
REQ-029 The first read after rst deasserts SHALL be no earlier than the cycle after deassertion.

Structure
REQ-030 Shared package fifo_rd_pkg SHALL hold DATA_WIDTH default, PKT_LEN default, the buffer depth constant (3), and the pkt_count width (16).
REQ-031 The 3-entry buffer SHALL be a sub-module stream_buf (push, pop, head, occupancy); issue logic and packet counters SHALL live in fifo_stream_reader.

Verification
REQ-032 Preload FIFO with 0x00..0x0F, m_ready=1 -> 16 beats on consecutive cycles, data 0x00..0x0F, m_last only on 0x0F, pkt_count=1.
REQ-033 Preload 0x10..0x1F, m_ready toggled 1/0 each cycle -> data order intact, m_data stable while stalled, no FIFO reads beyond 3 outstanding.
REQ-034 m_ready=0 with FIFO non-empty -> exactly 3 reads issued, then fifo_rd_en=0; release -> no loss or duplication.
REQ-035 Feed 8 words, FIFO empties, then 8 more -> m_last on the 16th beat overall, pkt_count=1.
REQ-036 Assert rst one cycle after a rd_en with 2 beats buffered -> m_valid=0 next cycle, landing word dropped, counters 0.
REQ-037 PKT_LEN=1, 0xFFFF packets then 1 more -> m_last on every beat, pkt_count wraps to 0.
